// File: rtl/axi_wr_pkg.sv
// Shared types and AXI encodings for the data-store write controller.
package axi_wr_pkg;

  localparam int AXI_ADDR_W = 32;
  localparam int AXI_DATA_W = 16;

  localparam logic [2:0] AXI_SIZE_2B    = 3'b001;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} wr_state_e;

  typedef struct packed {
    logic [AXI_ADDR_W-1:0] addr;
    logic [AXI_DATA_W-1:0] data;
  } wr_entry_t;

endpackage

// File: rtl/wr_queue.sv
// In-order circular store queue; entries/valid are presented oldest-first
// (index 0 is the head) so a search can pick the youngest match by position.
module wr_queue
  import axi_wr_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  wr_entry_t             push_entry,
  input  logic                  pop,
  output wr_entry_t             head,
  output logic [CW-1:0]         count,
  output logic                  full,
  output logic                  empty,
  output wr_entry_t [DEPTH-1:0] entries,
  output logic [DEPTH-1:0]      valid
);

  wr_entry_t       mem [DEPTH];
  logic [PW-1:0]   rd_ptr, wr_ptr;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_entry;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    assign entries[i] = mem[rd_ptr + PW'(i)];
    assign valid[i]   = CW'(i) < count;
  end

  assign head  = entries[0];
  assign full  = count == CW'(DEPTH);
  assign empty = count == '0;

endmodule

// File: rtl/axi_wr_ctrl.sv
// Single-beat AXI4 store issuer fed from an in-order queue: AW, then W, then B.
// Optional STORE_FWD_EN builds a youngest-match forwarding lookup over the queue.
module axi_wr_ctrl
  import axi_wr_pkg::*;
#(
  parameter int ID_WIDTH    = 4,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 16,
  parameter int QUEUE_DEPTH = 4,
  parameter logic [ID_WIDTH-1:0] WR_ID = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_data,
  output logic                  busy,
  output logic                  wr_err,
  input  logic [ADDR_WIDTH-1:0] fwd_addr,
  output logic                  fwd_hit,
  output logic [DATA_WIDTH-1:0] fwd_data,
  output logic [ID_WIDTH-1:0]   awid_m_inf,
  output logic [ADDR_WIDTH-1:0] awaddr_m_inf,
  output logic [2:0]            awsize_m_inf,
  output logic [1:0]            awburst_m_inf,
  output logic [6:0]            awlen_m_inf,
  output logic                  awvalid_m_inf,
  input  logic                  awready_m_inf,
  output logic [DATA_WIDTH-1:0] wdata_m_inf,
  output logic                  wlast_m_inf,
  output logic                  wvalid_m_inf,
  input  logic                  wready_m_inf,
  input  logic [ID_WIDTH-1:0]   bid_m_inf,
  input  logic [1:0]            bresp_m_inf,
  input  logic                  bvalid_m_inf,
  output logic                  bready_m_inf
);

  localparam int CW = $clog2(QUEUE_DEPTH) + 1;

  wr_state_e                   state;
  wr_entry_t                   push_entry, q_head, load_entry;
  wr_entry_t [QUEUE_DEPTH-1:0] q_entries;
  logic [QUEUE_DEPTH-1:0]      q_valid;
  logic [CW-1:0]               q_count;
  logic                        q_full, q_empty, push, pop, more;

  assign push       = req_valid && !q_full;
  assign pop        = bready_m_inf && bvalid_m_inf;
  assign push_entry = '{addr: req_addr, data: req_data};
  assign req_ready  = !q_full;
  assign busy       = !q_empty || (state != IDLE);

  wr_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (q_head),
    .count      (q_count),
    .full       (q_full),
    .empty      (q_empty),
    .entries    (q_entries),
    .valid      (q_valid)
  );

  // On a B pop the next head is entries[1], or the same-cycle push if the
  // queue held only the retiring store.
  assign more       = (q_count > CW'(1)) || push;
  assign load_entry = (state == RESP) ? ((q_count > CW'(1)) ? q_entries[1] : push_entry)
                                      : q_head;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      awvalid_m_inf <= 1'b0;
      wvalid_m_inf  <= 1'b0;
      bready_m_inf  <= 1'b0;
      wr_err        <= 1'b0;
      awaddr_m_inf  <= '0;
      wdata_m_inf   <= '0;
    end else begin
      case (state)
        IDLE: if (!q_empty) begin
          state         <= ADDR;
          awvalid_m_inf <= 1'b1;
          awaddr_m_inf  <= {load_entry.addr[ADDR_WIDTH-1:1], 1'b0};
          wdata_m_inf   <= load_entry.data;
        end
        ADDR: if (awready_m_inf) begin
          awvalid_m_inf <= 1'b0;
          wvalid_m_inf  <= 1'b1;
          state         <= DATA;
        end
        DATA: if (wready_m_inf) begin
          wvalid_m_inf <= 1'b0;
          bready_m_inf <= 1'b1;
          state        <= RESP;
        end
        RESP: if (bvalid_m_inf) begin
          bready_m_inf <= 1'b0;
          if (bresp_m_inf != AXI_RESP_OKAY) wr_err <= 1'b1;
          if (more) begin
            state         <= ADDR;
            awvalid_m_inf <= 1'b1;
            awaddr_m_inf  <= {load_entry.addr[ADDR_WIDTH-1:1], 1'b0};
            wdata_m_inf   <= load_entry.data;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign awid_m_inf    = WR_ID;
  assign awsize_m_inf  = AXI_SIZE_2B;
  assign awburst_m_inf = AXI_BURST_INCR;
  assign awlen_m_inf   = '0;
  assign wlast_m_inf   = wvalid_m_inf;

`ifdef STORE_FWD_EN
  // Scan oldest to youngest so the last hit wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int i = 0; i < QUEUE_DEPTH; i++) begin
      if (q_valid[i] && (q_entries[i].addr[ADDR_WIDTH-1:1] == fwd_addr[ADDR_WIDTH-1:1])) begin
        fwd_hit  = 1'b1;
        fwd_data = q_entries[i].data;
      end
    end
  end
`else
  assign fwd_hit  = 1'b0;
  assign fwd_data = '0;
`endif

  logic unused_sig;
  assign unused_sig = ^{bid_m_inf, q_valid, q_entries, q_head, fwd_addr};

endmodule

// File: tb/tb_axi_wr_ctrl.sv
// Directed bench for axi_wr_ctrl with a small AXI slave / DRAM log model.
module tb_axi_wr_ctrl;

`ifdef STORE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0, rst = 1'b1;
  logic        req_valid = 1'b0, req_ready;
  logic [31:0] req_addr = '0;
  logic [15:0] req_data = '0;
  logic        busy, wr_err, fwd_hit;
  logic [31:0] fwd_addr = '0;
  logic [15:0] fwd_data;
  logic [3:0]  awid, bid = '0;
  logic [31:0] awaddr;
  logic [2:0]  awsize;
  logic [1:0]  awburst, bresp;
  logic [6:0]  awlen;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic [15:0] wdata;

  int checks = 0, errors = 0;

  // slave model state
  int aw_dly = 0, w_dly = 0, b_dly = 0, err_idx = -1;
  bit aw_hold = 1'b0;
  int aw_wait, w_wait, b_wait;
  int aw_n = 0, b_n = 0, aw_hi = 0, w_hi = 0, b_hi = 0;
  int stab_err = 0, overlap = 0, wlast_err = 0, push_bn = 0;
  bit aw_pend, w_pend;
  logic [31:0] aw_prev, aw_log[$];
  logic [15:0] w_prev, w_log[$];

  always #5 clk = ~clk;

  axi_wr_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_data(req_data),
    .busy(busy), .wr_err(wr_err),
    .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
    .awid_m_inf(awid), .awaddr_m_inf(awaddr), .awsize_m_inf(awsize), .awburst_m_inf(awburst),
    .awlen_m_inf(awlen), .awvalid_m_inf(awvalid), .awready_m_inf(awready),
    .wdata_m_inf(wdata), .wlast_m_inf(wlast), .wvalid_m_inf(wvalid), .wready_m_inf(wready),
    .bid_m_inf(bid), .bresp_m_inf(bresp), .bvalid_m_inf(bvalid), .bready_m_inf(bready)
  );

  // Readies are set on the falling edge for the next rising edge; handshakes
  // are logged here since valid and ready are both settled.
  always @(negedge clk or posedge rst) begin
    if (rst) begin
      awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
      aw_wait = 0; w_wait = 0; b_wait = 0; aw_pend = 1'b0; w_pend = 1'b0;
    end else begin
      if (awvalid && wvalid) overlap++;
      if (aw_pend && awaddr !== aw_prev) stab_err++;
      if (w_pend && wdata !== w_prev) stab_err++;
      if (wvalid && !wlast) wlast_err++;
      if (awvalid) aw_hi++;
      if (wvalid)  w_hi++;
      if (bready)  b_hi++;
      awready = awvalid && !aw_hold && (aw_wait >= aw_dly);
      if (!awvalid) aw_wait = 0; else if (!awready) aw_wait++;
      wready = wvalid && (w_wait >= w_dly);
      if (!wvalid) w_wait = 0; else if (!wready) w_wait++;
      bvalid = bready && (b_wait >= b_dly);
      bresp  = (bvalid && b_n == err_idx) ? 2'b10 : 2'b00;
      if (!bready) b_wait = 0; else if (!bvalid) b_wait++;
      if (awvalid && awready) begin aw_log.push_back(awaddr); aw_n++; end
      if (wvalid && wready)   w_log.push_back(wdata);
      if (bvalid && bready)   b_n++;
      aw_pend = awvalid && !awready; aw_prev = awaddr;
      w_pend  = wvalid && !wready;   w_prev  = wdata;
    end
  end

  task automatic do_reset();
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_data = '0; fwd_addr = '0;
    aw_hold = 1'b0; aw_dly = 0; w_dly = 0; b_dly = 0; err_idx = -1;
    aw_log.delete(); w_log.delete(); aw_n = 0; b_n = 0;
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic push(input logic [31:0] a, input logic [15:0] d);
    int n = 0;
    @(negedge clk); #1;
    req_valid = 1'b1; req_addr = a; req_data = d;
    while (!req_ready && n < 300) begin @(negedge clk); #1; n++; end
    if (n >= 300) begin
      checks++; errors++;
      $display("FAIL push_timeout addr %h still not accepted", a);
    end
    push_bn = b_n;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_b(input int target, input int budget, input string name);
    int n = 0;
    while (b_n < target && n < budget) begin @(negedge clk); #1; n++; end
    @(posedge clk); #1;
    checks++;
    if (b_n < target) begin
      errors++;
      $display("FAIL %s b_count got %0d exp %0d", name, b_n, target);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; #1;
    checks++;
    if ({req_ready, busy, awvalid, wvalid, bready, wr_err} !== 6'b100000) begin
      errors++; $display("FAIL reset_held flags got %b exp 100000",
                         {req_ready, busy, awvalid, wvalid, bready, wr_err});
    end
    do_reset(); #1;
    checks++;
    if ({req_ready, busy, awvalid, wvalid, wlast, bready, wr_err, fwd_hit} !== 8'b1000_0000) begin
      errors++; $display("FAIL reset_flags got %b exp 10000000",
                         {req_ready, busy, awvalid, wvalid, wlast, bready, wr_err, fwd_hit});
    end
    checks++;
    if (awaddr !== 32'h0 || wdata !== 16'h0 || fwd_data !== 16'h0) begin
      errors++; $display("FAIL reset_data got %h/%h/%h exp 0", awaddr, wdata, fwd_data);
    end
    checks++;
    if ({awid, awlen, awsize, awburst} !== {4'h0, 7'h0, 3'b001, 2'b01}) begin
      errors++; $display("FAIL reset_consts got %h exp %h",
                         {awid, awlen, awsize, awburst}, {4'h0, 7'h0, 3'b001, 2'b01});
    end
  endtask

  task automatic test_single();
    do_reset();
    push(32'h0000_1A3C, 16'hBEEF);
    checks++;
    if (awvalid !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL single_push_cycle awvalid/busy got %b%b exp 01", awvalid, busy);
    end
    @(posedge clk); #1;
    checks++;
    if (awvalid !== 1'b1 || awaddr !== 32'h0000_1A3C || awlen !== 7'd0 || awsize !== 3'd1 || wvalid !== 1'b0) begin
      errors++; $display("FAIL single_aw got v%b a%h exp v1 a00001a3c", awvalid, awaddr);
    end
    @(posedge clk); #1;
    checks++;
    if (wvalid !== 1'b1 || wlast !== 1'b1 || wdata !== 16'hBEEF || awvalid !== 1'b0) begin
      errors++; $display("FAIL single_w got v%b l%b d%h exp v1 l1 dbeef", wvalid, wlast, wdata);
    end
    @(posedge clk); #1;
    checks++;
    if (bready !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL single_resp bready/busy got %b%b exp 11", bready, busy);
    end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || bready !== 1'b0 || b_n != 1) begin
      errors++; $display("FAIL single_done busy %b bready %b bcnt %0d exp 0 0 1", busy, bready, b_n);
    end
    checks++;
    if (w_log.size() != 1 || w_log[0] !== 16'hBEEF) begin
      errors++; $display("FAIL single_dram got %0d entries exp 1 beef", w_log.size());
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    aw_dly = 5; w_dly = 3; b_dly = 7;
    aw_hi = 0; w_hi = 0; b_hi = 0; stab_err = 0; overlap = 0;
    push(32'h0000_3457, 16'h7E57);
    wait_b(1, 100, "bp_wait");
    repeat (3) @(posedge clk); #1;
    checks++;
    if (aw_hi != 6 || w_hi != 4 || b_hi != 8) begin
      errors++; $display("FAIL bp_hold_cycles got aw%0d w%0d b%0d exp aw6 w4 b8", aw_hi, w_hi, b_hi);
    end
    checks++;
    if (aw_n != 1 || aw_log[0] !== 32'h0000_3456 || w_log[0] !== 16'h7E57) begin
      errors++; $display("FAIL bp_txn got n%0d a%h d%h exp n1 a00003456 d7e57", aw_n, aw_log[0], w_log[0]);
    end
    checks++;
    if (stab_err != 0 || overlap != 0) begin
      errors++; $display("FAIL bp_stable got stab %0d overlap %0d exp 0 0", stab_err, overlap);
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL bp_busy got %b exp 0", busy); end
  endtask

  task automatic test_queue_full();
    logic [31:0] ea [5] = '{32'h2000, 32'h2002, 32'h2004, 32'h2006, 32'h2008};
    logic [15:0] ed [5] = '{16'hA000, 16'hA001, 16'hA002, 16'hA003, 16'hA004};
    do_reset();
    aw_hold = 1'b1;
    for (int i = 0; i < 4; i++) push(ea[i], ed[i]);
    checks++;
    if (req_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %b exp 0", req_ready); end
    fork
      push(32'h0000_2009, 16'hA004);
      begin
        repeat (3) @(negedge clk); #1;
        checks++;
        if (req_ready !== 1'b0 || b_n != 0) begin
          errors++; $display("FAIL full_held ready %b bcnt %0d exp 0 0", req_ready, b_n);
        end
        aw_hold = 1'b0;
      end
    join
    checks++;
    if (push_bn != 1) begin errors++; $display("FAIL full_fifth_accept bcnt got %0d exp 1", push_bn); end
    wait_b(5, 400, "full_drain");
    checks++;
    if (aw_log.size() != 5 || w_log.size() != 5) begin
      errors++; $display("FAIL full_count got %0d/%0d exp 5/5", aw_log.size(), w_log.size());
    end
    for (int i = 0; i < 5 && i < aw_log.size() && i < w_log.size(); i++) begin
      checks++;
      if (aw_log[i] !== ea[i] || w_log[i] !== ed[i]) begin
        errors++; $display("FAIL full_order[%0d] got %h/%h exp %h/%h", i, aw_log[i], w_log[i], ea[i], ed[i]);
      end
    end
  endtask

  task automatic test_error();
    int n = 0;
    do_reset();
    err_idx = 1;
    push(32'h0000_4000, 16'h0001);
    push(32'h0000_4002, 16'h0002);
    push(32'h0000_4004, 16'h0003);
    while (b_n < 2 && n < 100) begin @(negedge clk); #1; n++; end
    checks++;
    if (wr_err !== 1'b0) begin errors++; $display("FAIL err_before got %b exp 0", wr_err); end
    @(posedge clk); #1;
    checks++;
    if (wr_err !== 1'b1) begin errors++; $display("FAIL err_set got %b exp 1", wr_err); end
    wait_b(3, 100, "err_drain");
    repeat (4) @(posedge clk); #1;
    checks++;
    if (w_log.size() != 3 || w_log[2] !== 16'h0003 || wr_err !== 1'b1) begin
      errors++; $display("FAIL err_sticky stores %0d wr_err %b exp 3 1", w_log.size(), wr_err);
    end
    rst = 1'b1; #1;
    checks++;
    if (wr_err !== 1'b0) begin errors++; $display("FAIL err_clear got %b exp 0", wr_err); end
  endtask

  task automatic test_reset_mid();
    int n = 0, base;
    bit seen = 1'b0;
    do_reset();
    w_dly = 20;
    push(32'h0000_5000, 16'h5555);
    push(32'h0000_5002, 16'h6666);
    while (!wvalid && n < 50) begin @(negedge clk); #1; n++; end
    checks++;
    if (wvalid !== 1'b1) begin errors++; $display("FAIL mid_reach_data wvalid got %b exp 1", wvalid); end
    rst = 1'b1; #1;
    checks++;
    if ({wvalid, awvalid, bready, busy, req_ready} !== 5'b00001) begin
      errors++; $display("FAIL mid_reset got %b exp 00001", {wvalid, awvalid, bready, busy, req_ready});
    end
    repeat (2) @(negedge clk);
    #1 rst = 1'b0; w_dly = 0;
    base = aw_n;
    repeat (10) begin @(negedge clk); #1; if (awvalid) seen = 1'b1; end
    checks++;
    if (seen || aw_n != base || busy !== 1'b0) begin
      errors++; $display("FAIL mid_no_spurious awseen %b aw %0d busy %b exp 0 %0d 0", seen, aw_n, busy, base);
    end
  endtask

  task automatic test_fwd();
    do_reset();
    aw_hold = 1'b1;
    push(32'h0000_0100, 16'h1111);
    push(32'h0000_0100, 16'h2222);
    push(32'h0000_0200, 16'h3333);
    fwd_addr = 32'h0000_0101; #1;
    checks++;
    if (fwd_hit !== FWD || fwd_data !== (FWD ? 16'h2222 : 16'h0)) begin
      errors++; $display("FAIL fwd_youngest got %b %h exp %b %h", fwd_hit, fwd_data, FWD, FWD ? 16'h2222 : 16'h0);
    end
    fwd_addr = 32'h0000_0201; #1;
    checks++;
    if (fwd_hit !== FWD || fwd_data !== (FWD ? 16'h3333 : 16'h0)) begin
      errors++; $display("FAIL fwd_other got %b %h exp %b %h", fwd_hit, fwd_data, FWD, FWD ? 16'h3333 : 16'h0);
    end
    @(negedge clk); #1;
    req_valid = 1'b1; req_addr = 32'h0000_0300; req_data = 16'h4444; fwd_addr = 32'h0000_0300; #1;
    checks++;
    if (fwd_hit !== 1'b0) begin errors++; $display("FAIL fwd_same_cycle got %b exp 0", fwd_hit); end
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++;
    if (fwd_hit !== FWD || fwd_data !== (FWD ? 16'h4444 : 16'h0)) begin
      errors++; $display("FAIL fwd_after_push got %b %h exp %b %h", fwd_hit, fwd_data, FWD, FWD ? 16'h4444 : 16'h0);
    end
    aw_hold = 1'b0;
    wait_b(4, 200, "fwd_drain");
    fwd_addr = 32'h0000_0101; #1;
    checks++;
    if (fwd_hit !== 1'b0) begin errors++; $display("FAIL fwd_empty got %b exp 0", fwd_hit); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_queue_full();
    test_error();
    test_reset_mid();
    test_fwd();
    checks++;
    if (overlap != 0 || wlast_err != 0) begin
      errors++; $display("FAIL protocol overlap %0d wlast %0d exp 0 0", overlap, wlast_err);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
